// File: rtl/sdft_pkg.sv
// sdft_pkg: shared state encoding and width helpers for the sliding-DFT sequencer.
package sdft_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SWEEP, DRAIN} state_t;

    function automatic int bin_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int delta_width(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/sdft_delay_line.sv
// sdft_delay_line: fixed-depth shift register with async clear, used to delay MAC issue into writeback.
module sdft_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < DEPTH; k++) r_pipe[k] <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int k = 1; k < DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/sdft_sequencer.sv
// sdft_sequencer: per-frame sample intake, comb delta, single-MAC bin sweep and bin-bank port arbitration.
module sdft_sequencer
    import sdft_pkg::*;
#(
    parameter int data_width   = 8,
    parameter int freq_bins    = 16,
    parameter int pipe_latency = 2,
    localparam int BW = bin_width(freq_bins),
    localparam int DW = delta_width(data_width)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_sample_valid,
    input  logic signed [data_width-1:0] i_sample,
    output logic                         o_sample_ready,
    output logic signed [DW-1:0]         o_delta,
    output logic [BW-1:0]                o_bin_addr,
    output logic                         o_mac_en,
    output logic                         o_wb_en,
    output logic [BW-1:0]                o_wb_addr,
    input  logic                         i_rd_req,
    output logic                         o_rd_grant,
    output logic                         o_busy,
    output logic                         o_frame_done
);

    localparam int CW = $clog2(freq_bins + pipe_latency + 1);

    state_t                       r_state, w_next;
    logic [CW-1:0]                r_cnt;
    logic                         r_live, r_done, r_fair;
    logic [BW-1:0]                r_wptr;
    logic signed [data_width-1:0] r_hist [freq_bins];
    logic signed [DW-1:0]         r_delta;
    logic                         w_idle, w_accept;
    logic [BW:0]                  w_wb;

    // r_live keeps the handshake outputs low until the first clock after reset
    assign w_idle         = r_live && r_state == IDLE;
    assign o_sample_ready = w_idle && !(i_rd_req && r_fair);
    assign o_rd_grant     = w_idle && i_rd_req && (r_fair || !i_sample_valid);
    assign w_accept       = i_sample_valid && o_sample_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_live  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || r_state == IDLE) ? '0 : r_cnt + CW'(1);
            r_live  <= 1'b1;
            r_done  <= r_state == DRAIN && w_next == IDLE;
        end
    end

    always_comb begin
        w_next = (r_state == IDLE)  ? (w_accept ? LOAD : IDLE) :
                 (r_state == LOAD)  ? SWEEP :
                 (r_state == SWEEP) ? ((r_cnt == CW'(freq_bins - 1)) ? DRAIN : SWEEP) :
                                      ((r_cnt == CW'(pipe_latency - 1)) ? IDLE : DRAIN);
    end

    always_comb begin
        o_busy     = r_state != IDLE;
        o_mac_en   = r_state == SWEEP;
        o_bin_addr = (r_state == SWEEP) ? r_cnt[BW-1:0] : '0;
    end

    // Sample, delta and history are all captured on the accepting edge so the input may change in LOAD
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < freq_bins; k++) r_hist[k] <= '0;
            r_wptr  <= '0;
            r_delta <= '0;
            r_fair  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hist[r_wptr] <= i_sample;
                r_wptr         <= r_wptr + BW'(1);
                r_delta        <= $signed({i_sample[data_width-1], i_sample})
                                - $signed({r_hist[r_wptr][data_width-1], r_hist[r_wptr]});
            end
            if (w_accept)
                r_fair <= 1'b1;
            else if (o_rd_grant)
                r_fair <= 1'b0;
        end
    end

    sdft_delay_line #(.DEPTH(pipe_latency), .WIDTH(BW + 1)) u_wb_delay (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     ({o_mac_en, o_bin_addr}),
        .o_q     (w_wb)
    );

    assign o_wb_en      = w_wb[BW];
    assign o_wb_addr    = w_wb[BW-1:0];
    assign o_delta      = r_delta;
    assign o_frame_done = r_done;

endmodule

// File: tb/tb_sdft_sequencer.sv
// tb_sdft_sequencer: scoreboard bench for sdft_sequencer at pipe_latency 2, plus a pipe_latency 4 instance.
module tb_sdft_sequencer;

    localparam int N  = 16;
    localparam int L  = 2;
    localparam int L4 = 4;
    localparam int DW = 8;

    logic                 i_clk = 1'b0, i_reset = 1'b0, i_sample_valid = 1'b0, i_rd_req = 1'b0;
    logic signed [DW-1:0] i_sample = '0;

    logic                 o_sample_ready, o_mac_en, o_wb_en, o_rd_grant, o_busy, o_frame_done;
    logic signed [DW:0]   o_delta;
    logic [3:0]           o_bin_addr, o_wb_addr;

    logic                 d4_ready, d4_mac, d4_wb_en, d4_grant, d4_busy, d4_done;
    logic signed [DW:0]   d4_delta;
    logic [3:0]           d4_bin, d4_wb_addr;

    int n_chk = 0, n_pass = 0;
    logic signed [DW-1:0] m_hist [N];
    int m_wptr;
    logic signed [DW:0] q_delta [$];
    int q_wa [$];
    int q_wc [$];

    sdft_sequencer #(.data_width(DW), .freq_bins(N), .pipe_latency(L)) u_dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_sample_valid(i_sample_valid), .i_sample(i_sample),
        .o_sample_ready(o_sample_ready), .o_delta(o_delta), .o_bin_addr(o_bin_addr), .o_mac_en(o_mac_en),
        .o_wb_en(o_wb_en), .o_wb_addr(o_wb_addr), .i_rd_req(i_rd_req), .o_rd_grant(o_rd_grant),
        .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    sdft_sequencer #(.data_width(DW), .freq_bins(N), .pipe_latency(L4)) u_dut4 (
        .i_clk(i_clk), .i_reset(i_reset), .i_sample_valid(i_sample_valid), .i_sample(i_sample),
        .o_sample_ready(d4_ready), .o_delta(d4_delta), .o_bin_addr(d4_bin), .o_mac_en(d4_mac),
        .o_wb_en(d4_wb_en), .o_wb_addr(d4_wb_addr), .i_rd_req(i_rd_req), .o_rd_grant(d4_grant),
        .o_busy(d4_busy), .o_frame_done(d4_done)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic clear_model();
        for (int k = 0; k < N; k++) m_hist[k] = '0;
        m_wptr = 0;
        q_delta.delete();
        q_wa.delete();
        q_wc.delete();
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        i_sample_valid = 1'b0;
        i_rd_req = 1'b0;
        clear_model();
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
    endtask

    // One full frame: accept s, then check every cycle through the frame_done pulse
    task automatic frame(input logic signed [DW-1:0] s);
        logic signed [DW:0] d;
        logic [6:0] exp_v, got_v;
        bit em;
        for (int w = 0; w < 50 && !o_sample_ready; w++) @(negedge i_clk);
        n_chk++;
        if (!o_sample_ready) begin
            $display("FAIL accept_timeout sample_ready got 0 exp 1");
            return;
        end
        n_pass++;
        i_sample_valid = 1'b1;
        i_sample = s;
        d = s;
        d = d - m_hist[m_wptr];
        q_delta.push_back(d);
        m_hist[m_wptr] = s;
        m_wptr = (m_wptr + 1) % N;
        for (int c = 1; c <= N + 2 + L; c++) begin
            @(negedge i_clk);
            if (c == 1) begin
                i_sample_valid = 1'b0;
                d = q_delta.pop_front();
                n_chk++;
                if (o_delta !== d) $display("FAIL delta got %0d exp %0d", o_delta, d);
                else n_pass++;
            end
            em = c >= 2 && c <= N + 1;
            if (em) begin
                q_wa.push_back(c - 2);
                q_wc.push_back(c + L);
            end
            exp_v = {c <= N + 1 + L, em, em ? 4'(c - 2) : 4'd0, c == N + 2 + L};
            got_v = {o_busy, o_mac_en, o_mac_en ? o_bin_addr : 4'd0, o_frame_done};
            n_chk++;
            if (got_v !== exp_v) $display("FAIL ctl cycle %0d busy/mac/bin/done got %b exp %b", c, got_v, exp_v);
            else n_pass++;
            if (o_wb_en === 1'b1) begin
                n_chk++;
                if (q_wa.size() == 0) $display("FAIL wb_spurious cycle %0d addr got %0d exp none", c, o_wb_addr);
                else begin
                    int ea, ec;
                    ea = q_wa.pop_front();
                    ec = q_wc.pop_front();
                    if (int'(o_wb_addr) != ea || c != ec)
                        $display("FAIL wb addr/cycle got %0d/%0d exp %0d/%0d", o_wb_addr, c, ea, ec);
                    else n_pass++;
                end
            end
        end
        n_chk++;
        if (q_wa.size() != 0) $display("FAIL wb_missing left got %0d exp 0", q_wa.size());
        else n_pass++;
        q_wa.delete();
        q_wc.delete();
    endtask

    task automatic test_reset();
        logic [8:0] v;
        #1 i_reset = 1'b1;
        i_rd_req = 1'b1;
        i_sample_valid = 1'b1;
        clear_model();
        repeat (2) @(negedge i_clk);
        v = {o_sample_ready, o_rd_grant, o_busy, o_mac_en, o_wb_en, o_frame_done, |o_delta, |o_bin_addr, |o_wb_addr};
        n_chk++;
        if (v !== 9'd0) $display("FAIL reset_outputs got %b exp %b", v, 9'd0);
        else n_pass++;
        i_rd_req = 1'b0;
        i_sample_valid = 1'b0;
        i_reset = 1'b0;
        #1;
        n_chk++;
        if (o_sample_ready !== 1'b0) $display("FAIL ready_before_clock got %b exp 0", o_sample_ready);
        else n_pass++;
        @(negedge i_clk);
        n_chk++;
        if (o_sample_ready !== 1'b1) $display("FAIL ready_after_reset got %b exp 1", o_sample_ready);
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        frame(8'sd5);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int v = 1; v <= 17; v++) frame(DW'(v));
        n_chk++;
        if (o_delta !== 9'sd16) $display("FAIL wrap_delta got %0d exp 16", o_delta);
        else n_pass++;
    endtask

    task automatic test_extremes();
        do_reset();
        frame(8'sd127);
        for (int k = 0; k < 15; k++) frame(8'sd0);
        frame(-8'sd128);
        n_chk++;
        if (o_delta !== -9'sd255) $display("FAIL extreme_delta got %0d exp -255", o_delta);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        bit hit;
        int wbs;
        logic [2:0] v;
        do_reset();
        i_sample_valid = 1'b1;
        i_sample = 8'sd9;
        hit = 0;
        for (int c = 1; c < 40 && !hit; c++) begin
            @(negedge i_clk);
            i_sample_valid = 1'b0;
            if (o_mac_en && o_bin_addr == 4'd7) hit = 1;
        end
        n_chk++;
        if (!hit) $display("FAIL sweep_bin7_timeout got 0 exp 1");
        else n_pass++;
        i_reset = 1'b1;
        clear_model();
        @(negedge i_clk);
        v = {o_busy, o_mac_en, o_wb_en};
        n_chk++;
        if (v !== 3'b000) $display("FAIL midframe_reset busy/mac/wb got %b exp 000", v);
        else n_pass++;
        i_reset = 1'b0;
        wbs = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge i_clk);
            if (o_wb_en !== 1'b0) wbs++;
        end
        n_chk++;
        if (wbs != 0) $display("FAIL dropped_wb got %0d exp 0", wbs);
        else n_pass++;
        frame(8'sd3);
    endtask

    task automatic test_arbitration();
        int ev [$];
        int bad;
        @(negedge i_clk);
        i_reset = 1'b1;
        i_rd_req = 1'b1;
        i_sample_valid = 1'b1;
        i_sample = '0;
        clear_model();
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 300 && ev.size() < 4; c++) begin
            @(negedge i_clk);
            if (o_rd_grant && o_busy) bad++;
            if (o_sample_ready && i_sample_valid) ev.push_back(0);
            else if (o_rd_grant) ev.push_back(1);
        end
        i_rd_req = 1'b0;
        i_sample_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (k >= ev.size()) $display("FAIL arb_event%0d got none exp %0d", k, k % 2);
            else if (ev[k] != k % 2) $display("FAIL arb_event%0d got %0d exp %0d", k, ev[k], k % 2);
            else n_pass++;
        end
        n_chk++;
        if (bad != 0) $display("FAIL grant_while_busy got %0d exp 0", bad);
        else n_pass++;
    endtask

    task automatic test_latency4();
        logic [5:0] exp_v, got_v;
        bit em;
        do_reset();
        i_sample_valid = 1'b1;
        i_sample = 8'sd1;
        for (int c = 1; c <= N + 2 + L4; c++) begin
            @(negedge i_clk);
            i_sample_valid = 1'b0;
            em = c >= 2 && c <= N + 1;
            if (em) begin
                q_wa.push_back(c - 2);
                q_wc.push_back(c + L4);
            end
            exp_v = {em, em ? 4'(c - 2) : 4'd0, c == N + 2 + L4};
            got_v = {d4_mac, d4_mac ? d4_bin : 4'd0, d4_done};
            n_chk++;
            if (got_v !== exp_v) $display("FAIL l4_ctl cycle %0d mac/bin/done got %b exp %b", c, got_v, exp_v);
            else n_pass++;
            if (d4_wb_en === 1'b1) begin
                n_chk++;
                if (q_wa.size() == 0) $display("FAIL l4_wb_spurious cycle %0d got %0d exp none", c, d4_wb_addr);
                else begin
                    int ea, ec;
                    ea = q_wa.pop_front();
                    ec = q_wc.pop_front();
                    if (int'(d4_wb_addr) != ea || c != ec)
                        $display("FAIL l4_wb addr/cycle got %0d/%0d exp %0d/%0d", d4_wb_addr, c, ea, ec);
                    else n_pass++;
                end
            end
        end
        n_chk++;
        if (q_wa.size() != 0) $display("FAIL l4_wb_missing left got %0d exp 0", q_wa.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_extremes();
        test_reset_midframe();
        test_arbitration();
        test_latency4();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
